// File: rtl/riscv_load_writeback.sv
// +--------------------------------------------------------------------------+
// | riscv_load_writeback: in-order load queue, alignment/extension, reg write |
// | Optional: RISCV_WB_FORWARD_EN adds write-back forwarding outputs.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module riscv_load_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_waddr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_sign_i,
  input  logic [1:0]            req_offset_i,
  input  logic                  resp_valid_i,
  input  logic [DATA_WIDTH-1:0] resp_rdata_i,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_o,
`ifdef RISCV_WB_FORWARD_EN
  output logic                  fwd_a_o,
  output logic                  fwd_b_o,
  output logic                  fwd_c_o,
`endif
  output logic                  err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] ent_waddr_q [FIFO_DEPTH];
  logic [1:0]            ent_size_q  [FIFO_DEPTH];
  logic                  ent_sign_q  [FIFO_DEPTH];
  logic [1:0]            ent_off_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  push, pop, spurious, bad_align;
  logic [ADDR_WIDTH-1:0] head_waddr;
  logic [1:0]            head_size, head_off;
  logic                  head_sign;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] raddr_w [3];

  // Ready depends only on the registered occupancy, never on this cycle's response.
  assign req_ready_o = (count_q < C_DEPTH);
  assign push        = req_valid_i & req_ready_o;
  assign pop         = resp_valid_i & (count_q != '0);
  assign spurious    = resp_valid_i & (count_q == '0);

  assign head_waddr = ent_waddr_q[rptr_q];
  assign head_size  = ent_size_q[rptr_q];
  assign head_sign  = ent_sign_q[rptr_q];
  assign head_off   = ent_off_q[rptr_q];

  assign bad_align = (head_size == 2'b11) | ((head_size == 2'b01) & head_off[0]);

  always_comb begin
    sel_byte = resp_rdata_i[{head_off, 3'b000} +: 8];
    sel_half = resp_rdata_i[{head_off[1], 4'b0000} +: 16];
    aligned  = resp_rdata_i;
    case (head_size)
      2'b00:   aligned = {{(DATA_WIDTH-8){head_sign & sel_byte[7]}}, sel_byte};
      2'b01:   aligned = {{(DATA_WIDTH-16){head_sign & sel_half[15]}}, sel_half};
      default: aligned = resp_rdata_i;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    valid_d = valid_q;
    if (pop)  valid_d[rptr_q] = 1'b0;
    if (push) valid_d[wptr_q] = 1'b1;
    we_d    = pop & (head_waddr != '0);
    waddr_d = pop ? head_waddr : waddr_q;
    wdata_d = pop ? aligned : wdata_q;
    err_d   = err_q | spurious | (pop & bad_align);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_waddr_q[wptr_q] <= req_waddr_i;
      ent_size_q[wptr_q]  <= req_size_i;
      ent_sign_q[wptr_q]  <= req_sign_i;
      ent_off_q[wptr_q]   <= req_offset_i;
    end
  end

  assign raddr_w[0] = raddr_a_i;
  assign raddr_w[1] = raddr_b_i;
  assign raddr_w[2] = raddr_c_i;

  // x0 reads never stall; with forwarding the write-back stage is bypassed instead.
  always_comb begin
    hazard_o = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (raddr_w[r] != '0) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (valid_q[i] && (ent_waddr_q[i] == raddr_w[r])) hazard_o = 1'b1;
        end
`ifndef RISCV_WB_FORWARD_EN
        if (we_q && (waddr_q == raddr_w[r])) hazard_o = 1'b1;
`endif
      end
    end
  end

`ifdef RISCV_WB_FORWARD_EN
  assign fwd_a_o = we_q & (waddr_q != '0) & (waddr_q == raddr_a_i);
  assign fwd_b_o = we_q & (waddr_q != '0) & (waddr_q == raddr_b_i);
  assign fwd_c_o = we_q & (waddr_q != '0) & (waddr_q == raddr_c_i);
`endif

  assign we_b_o    = we_q;
  assign waddr_b_o = waddr_q;
  assign wdata_b_o = wdata_q;
  assign err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_load_writeback.sv
// +--------------------------------------------------------------------------+
// | tb_riscv_load_writeback: scoreboard bench for riscv_load_writeback        |
// | Honours RISCV_WB_FORWARD_EN for the forwarding outputs.                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_riscv_load_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_waddr = '0;
  logic [1:0]  req_size = '0;
  logic        req_sign = 1'b0;
  logic [1:0]  req_offset = '0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        we_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [4:0]  raddr_a = '0, raddr_b = '0, raddr_c = '0;
  logic        hazard, err;
`ifdef RISCV_WB_FORWARD_EN
  logic        fwd_a, fwd_b, fwd_c;
`endif

  riscv_load_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_waddr_i(req_waddr), .req_size_i(req_size),
    .req_sign_i(req_sign), .req_offset_i(req_offset),
    .resp_valid_i(resp_valid), .resp_rdata_i(resp_rdata),
    .we_b_o(we_b), .waddr_b_o(waddr_b), .wdata_b_o(wdata_b),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .hazard_o(hazard),
`ifdef RISCV_WB_FORWARD_EN
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .fwd_c_o(fwd_c),
`endif
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] size;
    logic       sign;
    logic [1:0] off;
  } ld_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
  } wb_t;

  ld_t pend_q[$];
  wb_t exp_q[$];
  logic err_exp = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  function automatic logic [31:0] model_data(input logic [31:0] r, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = off[1] ? r[31:16] : r[15:0];
    case (sz)
      2'b00:   model_data = (sg && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
      2'b01:   model_data = (sg && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
      default: model_data = r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    resp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    pend_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic [1:0] sz, input logic sg,
                       input logic [1:0] off);
    ld_t l;
    req_valid = 1'b1; req_waddr = wa; req_size = sz; req_sign = sg; req_offset = off;
    tick();
    req_valid = 1'b0;
    l.waddr = wa; l.size = sz; l.sign = sg; l.off = off;
    pend_q.push_back(l);
  endtask

  // Drives one response, scores the write-back seen one cycle later.
  task automatic respond(input logic [31:0] rdata, input string tag);
    ld_t l;
    wb_t e;
    l = pend_q.pop_front();
    e.we = (l.waddr != 5'd0);
    e.waddr = l.waddr;
    e.data = model_data(rdata, l.size, l.sign, l.off);
    if (l.size == 2'b11 || (l.size == 2'b01 && l.off[0])) err_exp = 1'b1;
    exp_q.push_back(e);
    resp_valid = 1'b1;
    resp_rdata = rdata;
    tick();
    resp_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (we_b !== e.we) begin
      n_fail++; $display("FAIL %s we_b_o: got %b want %b", tag, we_b, e.we);
    end
    if (e.we) begin
      n_tests++;
      if (waddr_b !== e.waddr || wdata_b !== e.data) begin
        n_fail++;
        $display("FAIL %s wb: got x%0d=%h want x%0d=%h", tag, waddr_b, wdata_b, e.waddr, e.data);
      end
    end
    n_tests++;
    if (err !== err_exp) begin
      n_fail++; $display("FAIL %s err_o: got %b want %b", tag, err, err_exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (req_ready !== 1'b1 || hazard !== 1'b0 || we_b !== 1'b0 || waddr_b !== 5'd0 ||
        wdata_b !== 32'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b hazard=%b we=%b waddr=%0d wdata=%h err=%b",
               req_ready, hazard, we_b, waddr_b, wdata_b, err);
    end
  endtask

  task automatic test_signed_byte();
    issue(5'd5, 2'b00, 1'b1, 2'd2);
    respond(32'h12803456, "signed_byte");
  endtask

  task automatic test_queue_fill();
    issue(5'd9, 2'b10, 1'b0, 2'd0);
    issue(5'd10, 2'b10, 1'b0, 2'd0);
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_ready_full: got %b want 0", req_ready);
    end
    respond(32'hCAFEBABE, "fill_first");
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_ready_after_pop: got %b want 1", req_ready);
    end
    respond(32'h01234567, "fill_second");
  endtask

  task automatic test_hazard();
    raddr_a = 5'd0; raddr_b = 5'd7;
    issue(5'd7, 2'b10, 1'b0, 2'd0);
    n_tests++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL hazard_pending: got %b want 1", hazard);
    end
    respond(32'h000000AA, "hazard_wb");
    n_tests++;
`ifdef RISCV_WB_FORWARD_EN
    if (hazard !== 1'b0 || fwd_b !== 1'b1 || fwd_a !== 1'b0) begin
      n_fail++; $display("FAIL hazard_wb_cycle: got hz=%b fb=%b fa=%b want 0 1 0", hazard, fwd_b, fwd_a);
    end
`else
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL hazard_wb_cycle: got %b want 1", hazard);
    end
`endif
    tick();
    n_tests++;
    if (hazard !== 1'b0 || we_b !== 1'b0 || waddr_b !== 5'd7 || wdata_b !== 32'h000000AA) begin
      n_fail++;
      $display("FAIL hazard_after: got hz=%b we=%b x%0d=%h want 0 0 x7=000000aa",
               hazard, we_b, waddr_b, wdata_b);
    end
    raddr_b = 5'd0;
    issue(5'd0, 2'b10, 1'b0, 2'd0);
    n_tests++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL hazard_x0: got %b want 0", hazard);
    end
    respond(32'hFFFFFFFF, "x0_load");
  endtask

  task automatic test_forward();
    raddr_c = 5'd3;
    issue(5'd3, 2'b10, 1'b0, 2'd0);
    respond(32'h33333333, "fwd_wb");
    n_tests++;
`ifdef RISCV_WB_FORWARD_EN
    if (fwd_c !== 1'b1 || hazard !== 1'b0) begin
      n_fail++; $display("FAIL fwd_c: got fwd=%b hz=%b want 1 0", fwd_c, hazard);
    end
`else
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL wb_term_hazard: got %b want 1", hazard);
    end
`endif
    raddr_c = 5'd0;
    tick();
  endtask

  task automatic test_misaligned();
    issue(5'd14, 2'b01, 1'b1, 2'd1);
    respond(32'h00008123, "half_misaligned");
    issue(5'd15, 2'b11, 1'b1, 2'd3);
    respond(32'h87654321, "reserved_size");
  endtask

  task automatic test_spurious();
    do_reset();
    resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
    tick();
    resp_valid = 1'b0;
    err_exp = 1'b1;
    n_tests++;
    if (we_b !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL spurious: got we=%b err=%b want 0 1", we_b, err);
    end
    // spurious response in the same cycle as an accepted issue
    req_valid = 1'b1; req_waddr = 5'd20; req_size = 2'b10; req_sign = 1'b0; req_offset = 2'd0;
    resp_valid = 1'b1;
    tick();
    req_valid = 1'b0; resp_valid = 1'b0;
    pend_q.push_back(ld_t'{5'd20, 2'b10, 1'b0, 2'd0});
    n_tests++;
    if (we_b !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL spurious_with_push: got we=%b err=%b want 0 1", we_b, err);
    end
    respond(32'h00000055, "after_spurious");
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: got %b want 0", err);
    end
  endtask

  task automatic test_half_reset();
    issue(5'd12, 2'b01, 1'b0, 2'd2);
    respond(32'hBEEF0000, "half_zext");
    raddr_a = 5'd13;
    issue(5'd13, 2'b10, 1'b0, 2'd0);
    resp_valid = 1'b1; resp_rdata = 32'h11111111; rst = 1'b1;
    tick();
    resp_valid = 1'b0; rst = 1'b0;
    pend_q.delete();
    err_exp = 1'b0;
    n_tests++;
    if (we_b !== 1'b0 || req_ready !== 1'b1 || hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got we=%b ready=%b hz=%b want 0 1 0", we_b, req_ready, hazard);
    end
    raddr_a = 5'd0;
  endtask

  task automatic test_back_to_back();
    issue(5'd1, 2'b00, 1'b0, 2'd3);
    issue(5'd2, 2'b01, 1'b1, 2'd0);
    respond(32'hAB000000, "b2b_first");
    respond(32'h0000F00F, "b2b_second");
    issue(5'd3, 2'b10, 1'b0, 2'd0);
    req_valid = 1'b1; req_waddr = 5'd4; req_size = 2'b00; req_sign = 1'b1; req_offset = 2'd1;
    respond(32'h76543210, "push_pop_same");
    req_valid = 1'b0;
    pend_q.push_back(ld_t'{5'd4, 2'b00, 1'b1, 2'd1});
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL push_pop_ready: got %b want 1", req_ready);
    end
    respond(32'h0000FF00, "after_push_pop");
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_queue_fill();
    test_hazard();
    test_forward();
    test_misaligned();
    test_spurious();
    test_half_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
